// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the 8N1 byte receiver.
package uart_pkg;

    // Receiver state encoding (2 bits).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // ASCII characters of the "HELLO" sequence consumed downstream.
    localparam logic [7:0] CH_H = 8'h48;
    localparam logic [7:0] CH_E = 8'h45;
    localparam logic [7:0] CH_L = 8'h4C;
    localparam logic [7:0] CH_O = 8'h4F;

    // Clocks per bit, truncated.
    function automatic int calc_bit_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Clocks from the start edge to the centre of the start bit.
    function automatic int calc_half_cnt(input int clk_freq, input int baud);
        return calc_bit_cnt(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Serial-in / byte-out bundle of the UART receiver.
interface uart_byte_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;

    // Line driver / byte consumer side.
    modport master (
        output rx,
        input  data,
        input  data_valid,
        input  frame_err
    );

    // Receiver side.
    modport slave (
        input  rx,
        output data,
        output data_valid,
        output frame_err
    );
endinterface

// File: rtl/rx_sync.sv
// N-flop synchronizer for an asynchronous input; resets to 1 (idle line).
// STAGES must be at least 2.
module rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the metastability chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 serial receiver: recovers bytes from rx, strobes data_valid on a good
// stop bit and frame_err on a bad one. Data is never updated on a bad frame.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic           clk_50mhz,
    input  logic           rst,
    uart_byte_rx_if.slave  bus
);

    localparam int BIT_CNT  = calc_bit_cnt(CLK_FREQ, BAUD);
    localparam int HALF_CNT = calc_half_cnt(CLK_FREQ, BAUD);
    localparam int CNT_W    = $clog2(BIT_CNT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] START = ST_START;
    localparam logic [1:0] DATA  = ST_DATA;
    localparam logic [1:0] STOP  = ST_STOP;

    logic             rx_s;
    logic             rx_prev_q;
    logic [1:0]       settle_q;
    logic             fall;

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic [7:0]       data_q,    data_d;
    logic             dv_q,      dv_d;
    logic             fe_q,      fe_d;

    rx_sync #(.STAGES(2)) u_rx_sync (
        .clk_i (clk_50mhz),
        .rst_i (rst),
        .d_i   (bus.rx),
        .q_o   (rx_s)
    );

    // Edge-detect register plus a settle counter: the synchronizer comes out
    // of reset holding 1, so edges are ignored until rx_prev_q holds a real
    // line sample. A line already low at reset release is therefore not a start.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            rx_prev_q <= 1'b1;
            settle_q  <= 2'd0;
        end else begin
            rx_prev_q <= rx_s;
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
        end
    end

    assign fall = (settle_q == 2'd3) && rx_prev_q && !rx_s;

    // Next-state logic: FSM, bit-period counter, bit index and shift register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        fe_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        // Line back high at mid-start: a glitch, not a frame.
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    // Leave at mid-stop so a following start edge is not missed.
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            fe_q      <= fe_d;
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = dv_q;
    assign bus.frame_err  = fe_q;

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Asynchronous serial (8N1) receiver that recovers bytes from a single RX pin and presents them as a parallel byte with a one-cycle valid strobe. It sits directly upstream of the `fsm_hello` character-sequence detector and supplies its `data` input. The detector must qualify each byte with `data_valid`, because `data` holds its value between frames. Framing errors are flagged and never delivered as data.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate in bits per second.
- Derived constant `BIT_CNT` = `CLK_FREQ/BAUD`, truncated (434 at defaults). `HALF_CNT` = `BIT_CNT/2` (217).
- `clk_50mhz`  in  1  system clock; the only clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `rx`  in  1  serial line; asynchronous to `clk_50mhz`; idles high.
- `data`  out  8  last correctly framed byte.
- `data_valid`  out  1  one-cycle pulse when `data` is updated.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low.

## Operation
- `rx` passes through a 2-flop synchronizer, then a third register for edge detection. All decisions use the synchronized value.
- State machine:
  - IDLE: wait for a falling edge (synchronized high→low). On the edge, go to START and clear the bit counter.
  - START: count to `HALF_CNT`-1, then sample.
    - Sample 0: go to DATA, clear the counter and bit index.
    - Sample 1: the start was a glitch; go to IDLE with no output.
  - DATA: every `BIT_CNT` clocks, sample one bit into the shift register, LSB first. After bit index 7, go to STOP.
  - STOP: after `BIT_CNT` clocks, sample, then go to IDLE.
    - Sample 1: load `data` from the shift register and pulse `data_valid`.
    - Sample 0: pulse `frame_err` and leave `data` unchanged.
- Returning to IDLE at mid-stop-bit allows back-to-back frames with zero idle time.
- Line break (rx held low): exactly one `frame_err`, then no activity until a new high→low edge.
- `data_valid` and `frame_err` are mutually exclusive and never assert in consecutive cycles.
- Bit counter width is `$clog2(BIT_CNT)`. The counter wraps to 0 at `BIT_CNT`-1.
- Reset values: state IDLE, counter 0, bit index 0, shift register 0x00, `data` 0x00, `data_valid` 0, `frame_err` 0. Synchronizer flops reset to 1 (line idle).
- Reset mid-frame aborts the frame with no output pulse. After reset is released, reception restarts on the next falling edge. Line low at reset release does not count as an edge.

## Timing
- Samples fall at bit centres: start at +`HALF_CNT`, data bit n at +`HALF_CNT`+(n+1)·`BIT_CNT`, stop at +`HALF_CNT`+9·`BIT_CNT` clocks after edge detection.
- `data_valid` / `frame_err` are registered and assert 4126 ±3 clocks after the `rx` pin falls (defaults). The bench checks this window.
- `data` changes only in the cycle `data_valid` rises and is stable otherwise.
- Baud tolerance: a correct frame is received with up to ±2% rate mismatch.

## Structure
- Package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, 2-bit encoding);
  - function computing `BIT_CNT`/`HALF_CNT` from the parameters;
  - character constants `CH_H`, `CH_E`, `CH_L`, `CH_O` for benches.
- Sub-module `rx_sync`: parameterized N-flop synchronizer with reset value 1, reusable for other asynchronous inputs.
- Remaining RTL (FSM, counters, shift register) in `uart_byte_rx`. Target 150–250 lines.

## Test plan
- Send "HELLO" (0x48 0x45 0x4C 0x4C 0x4F) at 115200 with 1 idle bit between frames → five `data_valid` pulses, `data` matching in order, `frame_err` never asserted.
- Glitch: `rx` low for 100 clocks, then high → no `data_valid`, no `frame_err`, FSM back in IDLE. A following 0x3C frame is received correctly.
- Framing error: 0x55 with stop bit 0, after a good 0x41 → one `frame_err` pulse, `data` stays 0x41.
- Reset mid-frame: assert `rst` for 5 clocks during data bit 4 of 0xFF → outputs 0 immediately. The next full frame 0xA5 yields `data`=0xA5 with one `data_valid`.
- Back-to-back: 0x00 and 0xFF with zero idle between frames → two `data_valid` pulses exactly 10·`BIT_CNT` ±1 clocks apart.
- Break: `rx` low for 30 bit times, then high → exactly one `frame_err`. The next 0x4F frame is received correctly.
